// File: rtl/bluemax_onchip_memory_dp.sv
// bluemax_onchip_memory_dp: true dual-port RAM, two Avalon-MM slaves, pipelined reads, post-reset clear engine
module bluemax_onchip_memory_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH = 4096,
    parameter int READ_LATENCY = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest,
    output logic                    init_busy
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic busy, coll;
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [NB-1:0] be [2];
    logic [DATA_WIDTH-1:0] wd [2];
    logic [1:0] cs, rd, wr, wait_r, in_rng, rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] d0 [2];
    logic [DATA_WIDTH-1:0] d1 [2];
    logic [1:0] v0, v1;

    assign busy = state == CLEAR;
    assign coll = s1_chipselect & s1_write & s2_chipselect & s2_write & (s1_address == s2_address);
    assign init_busy = busy;
    assign s1_waitrequest = busy;
    assign s2_waitrequest = busy | coll;
    assign s1_readdata = READ_LATENCY == 2 ? d1[0] : d0[0];
    assign s2_readdata = READ_LATENCY == 2 ? d1[1] : d0[1];
    assign s1_readdatavalid = READ_LATENCY == 2 ? v1[0] : v0[0];
    assign s2_readdatavalid = READ_LATENCY == 2 ? v1[1] : v0[1];

    // Port 1 is borrowed by the clear engine while busy; decode accepts per port
    always_comb begin
        addr[0] = busy ? cnt : s1_address;
        be[0] = busy ? '1 : s1_byteenable;
        wd[0] = busy ? CLEAR_VALUE : s1_writedata;
        addr[1] = s2_address;
        be[1] = s2_byteenable;
        wd[1] = s2_writedata;
        cs = {s2_chipselect, s1_chipselect};
        rd = {s2_read, s1_read};
        wr = {s2_write, s1_write};
        wait_r = {s2_waitrequest, s1_waitrequest};
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = {1'b0, addr[p]} < DEPTH_W;
            wr_acc[p] = (busy && p == 0) || (cs[p] && wr[p] && !wait_r[p]);
            rd_acc[p] = cs[p] && rd[p] && !wr[p] && !wait_r[p];
        end
    end

    // Clear engine: sweep every word once after reset, then hand the ports to the masters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= READY;
        end
    end

    // Byte-lane writes; out-of-range addresses are dropped so they never alias
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < NB; b++)
                if (wr_acc[p] && in_rng[p] && be[p][b])
                    mem[addr[p][IW-1:0]][8*b +: 8] <= wd[p][8*b +: 8];
    end

    // Read pipeline: stage 0 samples pre-write contents, stage 1 is the optional output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v0 <= '0;
            v1 <= '0;
            for (int p = 0; p < 2; p++) begin
                d0[p] <= '0;
                d1[p] <= '0;
            end
        end else begin
            v0 <= rd_acc;
            v1 <= v0;
            for (int p = 0; p < 2; p++) begin
                if (rd_acc[p]) d0[p] <= in_rng[p] ? mem[addr[p][IW-1:0]] : '0;
                if (v0[p]) d1[p] <= d0[p];
            end
        end
    end
endmodule

// File: doc/bluemax_onchip_memory_dp.md
Name: bluemax_onchip_memory_dp

Overview:
Parametrised true dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2) on one clock. Successor to the single-port 32x4096 platform memory. Adds:
- configurable width, depth and read latency
- pipelined reads with readdatavalid
- same-address write-collision arbitration
- hardware clear engine that zero-fills (or pattern-fills) the array after reset

Sits in bluemax_platform as CPU program/data memory shared with a DMA master.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8.
ADDR_WIDTH, 12, word address width.
DEPTH, 4096, words implemented; must be <= 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2 (2 adds an output register).
CLEAR_ON_RESET, 1, 1 = run the clear engine after reset; 0 = memory is ready immediately and contents are undefined.
CLEAR_VALUE, 0, DATA_WIDTH-bit value written to every word by the clear engine.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s1_address  in  ADDR_WIDTH  port 1 word address
s1_byteenable  in  DATA_WIDTH/8  port 1 byte lanes
s1_chipselect  in  1  port 1 select
s1_read  in  1  port 1 read request
s1_write  in  1  port 1 write request
s1_writedata  in  DATA_WIDTH  port 1 write data
s1_readdata  out  DATA_WIDTH  port 1 read data
s1_readdatavalid  out  1  port 1 read data valid
s1_waitrequest  out  1  port 1 stall
s2_*  (same nine signals as s1, prefix s2_)
init_busy  out  1  high while the clear engine runs

Behaviour:
- Reset (reset_n low, async): all outputs 0 except s1_waitrequest, s2_waitrequest and init_busy, which are 1 if CLEAR_ON_RESET=1, else 0. Read pipelines are flushed. Array contents are not modified by reset itself.
- Clear FSM has states CLEAR and READY.
  - Leaving reset: enter CLEAR if CLEAR_ON_RESET=1, else READY.
  - CLEAR: counter starts at 0. Each cycle, write CLEAR_VALUE (all byte lanes) to address counter via port 1 and increment. At counter=DEPTH-1, write that last word and go to READY on the next edge.
  - Clear takes exactly DEPTH cycles. init_busy and both waitrequests are 1 throughout CLEAR and drop together on entry to READY.
  - Reset asserted mid-clear restarts the clear from address 0.
- Request accepted: chipselect & (read | write) & ~waitrequest. Asserting read and write together is illegal master behaviour; write takes precedence and no readdatavalid is produced.
- Write: bytes with byteenable=1 are updated at the accepting edge. byteenable=0 is accepted and leaves the word unchanged.
- Read:
  - readdatavalid pulses exactly READ_LATENCY cycles after the accepting edge, with readdata.
  - One read can be accepted per cycle per port, fully pipelined.
  - readdata holds its last value when readdatavalid=0.
- Address >= DEPTH: writes are discarded; reads return 0 with normal latency.
- Collision rules in READY:
  - Both ports write the same address in the same cycle: s1 is accepted. s2_waitrequest=1 for that cycle only; s2 completes on the following cycle, so s2's data is final.
  - Any other combination: no wait states.
  - Read and write to the same address in the same cycle (same port or cross-port): the read returns old data.
- s*_waitrequest is combinational from the collision compare and the FSM state.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16, CLEAR_VALUE=32'hA5A5A5A5: release reset_n -> init_busy=1 for exactly 16 cycles; s1 then reads addresses 0..15 -> all 32'hA5A5A5A5, readdatavalid 1 cycle after each accept.
- Byte lanes: s1 writes 32'h11223344 to addr 5 with byteenable 4'b0101; s2 reads addr 5 -> 32'hA522A544 (over cleared 32'hA5A5A5A5).
- Collision: s1 writes 32'h1 and s2 writes 32'h2 to addr 7 in the same cycle -> s2_waitrequest=1 for 1 cycle, s1_waitrequest=0; subsequent read of addr 7 -> 32'h2.
- Mixed read/write: addr 3 holds 32'hDEAD; s1 writes 32'hBEEF while s2 reads addr 3 in the same cycle -> s2 gets 32'hDEAD; next read -> 32'hBEEF.
- READ_LATENCY=2 back-to-back reads of addr 0,1,2,3 on s2 -> 4 consecutive readdatavalid pulses starting 2 cycles after the first accept, in order.
- reset_n pulsed low at clear cycle 8 of 16 -> readdatavalid=0 immediately; clear restarts and init_busy stays high 16 more cycles after release.
